// File: rtl/reset_stage_sequencer.sv
// Ordered reset-release controller: releases NUM_STAGES active-low stage resets
// one at a time, each gated by a programmable delay and a per-stage ACK.
module reset_stage_sequencer #(
   parameter int NUM_STAGES = 3,
   parameter int DELAY_W    = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  rst_req,
   input  logic [DELAY_W-1:0]    cfg_delay,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  done,
   output logic                  timeout_err
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_STAGES - 1);
   localparam logic [DELAY_W-1:0] TIMEOUT_LD = DELAY_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_ASSERT   = 3'd0,
      S_DELAY    = 3'd1,
      S_RELEASE  = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_RUN      = 3'd4
   } state_t;

   state_t                  state_r, state_s;
   logic [IDX_W-1:0]        idx_r, idx_s;
   logic [DELAY_W-1:0]      cnt_r, cnt_s;
   logic [NUM_STAGES-1:0]   stage_rst_n_r, stage_rst_n_s;
   logic                    done_r, done_s;
   logic                    timeout_err_r, timeout_err_s;

   // Next-state and next-output logic; a reset request outranks every transition.
   always_comb begin
      state_s       = state_r;
      idx_s         = idx_r;
      cnt_s         = cnt_r;
      stage_rst_n_s = stage_rst_n_r;
      done_s        = done_r;
      timeout_err_s = timeout_err_r;

      if (rst_req && (state_r != S_ASSERT)) begin
         state_s       = S_ASSERT;
         idx_s         = {IDX_W{1'b0}};
         stage_rst_n_s = {NUM_STAGES{1'b0}};
         done_s        = 1'b0;
      end else begin
         case (state_r)
            S_ASSERT: begin
               if (!rst_req) begin
                  cnt_s   = cfg_delay;
                  state_s = S_DELAY;
               end else begin
                  state_s = S_ASSERT;
               end
            end
            S_DELAY: begin
               if (cnt_r == {DELAY_W{1'b0}}) begin
                  state_s = S_RELEASE;
               end else begin
                  cnt_s = cnt_r - DELAY_W'(1);
               end
            end
            S_RELEASE: begin
               stage_rst_n_s[idx_r] = 1'b1;
               cnt_s                = TIMEOUT_LD;
               state_s              = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // A missing ACK still advances so later stages are not held forever.
               if (stage_ack[idx_r] || (cnt_r == {DELAY_W{1'b0}})) begin
                  if (!stage_ack[idx_r]) begin
                     timeout_err_s = 1'b1;
                  end else begin
                     timeout_err_s = timeout_err_r;
                  end
                  if (idx_r == LAST_IDX) begin
                     done_s  = 1'b1;
                     state_s = S_RUN;
                  end else begin
                     idx_s   = idx_r + IDX_W'(1);
                     cnt_s   = cfg_delay;
                     state_s = S_DELAY;
                  end
               end else begin
                  cnt_s = cnt_r - DELAY_W'(1);
               end
            end
            S_RUN: begin
               state_s = S_RUN;
            end
            default: begin
               state_s       = S_ASSERT;
               idx_s         = {IDX_W{1'b0}};
               stage_rst_n_s = {NUM_STAGES{1'b0}};
               done_s        = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r       <= S_ASSERT;
         idx_r         <= {IDX_W{1'b0}};
         cnt_r         <= {DELAY_W{1'b0}};
         stage_rst_n_r <= {NUM_STAGES{1'b0}};
         done_r        <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         idx_r         <= idx_s;
         cnt_r         <= cnt_s;
         stage_rst_n_r <= stage_rst_n_s;
         done_r        <= done_s;
         timeout_err_r <= timeout_err_s;
      end
   end

   assign stage_rst_n = stage_rst_n_r;
   assign done        = done_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Self-checking bench for reset_stage_sequencer: constant vector table, timed
// corner sequences, and random traffic against an event-timer reference model.
module tb_reset_stage_sequencer;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int TO = 15;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          rst_req;
   logic [DW-1:0] cfg_delay;
   logic [N-1:0]  stage_ack;
   logic [N-1:0]  stage_rst_n;
   logic          done;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;

   // Reference model: count of released stages plus timers to the next event.
   int m_nrel;
   bit m_done;
   bit m_terr;
   bit m_hold;
   int m_count;
   int m_wait;

   reset_stage_sequencer #(.NUM_STAGES(N), .DELAY_W(DW), .TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .rst_req     (rst_req),
      .cfg_delay   (cfg_delay),
      .stage_ack   (stage_ack),
      .stage_rst_n (stage_rst_n),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          rn;
      logic          rq;
      logic [DW-1:0] d;
      logic [N-1:0]  ack;
      logic [N-1:0]  exp_rst_n;
      logic          exp_done;
      logic          exp_terr;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [N-1:0] therm(input int n);
      therm = N'((1 << n) - 1);
   endfunction

   // Stages released by edge k after the start edge, with ACKs held high.
   function automatic int n_exp(input int k, input int d);
      int n = 0;
      for (int i = 0; i < N; i++) begin
         if (k >= d + 2 + i * (d + 3)) n++;
      end
      return n;
   endfunction

   function automatic logic done_exp(input int k, input int d);
      return (k >= d + 2 + (N - 1) * (d + 3) + 1);
   endfunction

   task automatic check3(input string name, input logic [N-1:0] er, input logic ed, input logic et);
      checks++;
      if (stage_rst_n !== er || done !== ed || timeout_err !== et) begin
         errors++;
         $display("FAIL %s: got rst_n=%b done=%b terr=%b, want rst_n=%b done=%b terr=%b",
                  name, stage_rst_n, done, timeout_err, er, ed, et);
      end
   endtask

   task automatic m_advance(input int d);
      m_wait = 0;
      if (m_nrel == N) m_done = 1'b1;
      else m_count = d + 2;
   endtask

   task automatic model_step(input logic rn, input logic rq, input int d, input logic [N-1:0] ack);
      if (!rn) begin
         m_nrel = 0; m_done = 0; m_terr = 0; m_hold = 1; m_count = 0; m_wait = 0;
      end else if (rq) begin
         m_nrel = 0; m_done = 0; m_hold = 1; m_count = 0; m_wait = 0;
      end else if (m_hold) begin
         m_hold  = 0;
         m_count = d + 2;
      end else if (m_count > 0) begin
         m_count--;
         if (m_count == 0) begin
            m_nrel++;
            m_wait = TO + 1;
         end
      end else if (m_wait > 0) begin
         if (ack[m_nrel-1]) begin
            m_advance(d);
         end else begin
            m_wait--;
            if (m_wait == 0) begin
               m_terr = 1'b1;
               m_advance(d);
            end
         end
      end
   endtask

   task automatic cycle(input logic rn, input logic rq, input logic [DW-1:0] d, input logic [N-1:0] ack);
      reset_n   = rn;
      rst_req   = rq;
      cfg_delay = d;
      stage_ack = ack;
      model_step(rn, rq, int'(d), ack);
      @(posedge clock);
      @(negedge clock);
      check3("model", therm(m_nrel), m_done, m_terr);
   endtask

   initial begin
      reset_n = 1'b0; rst_req = 1'b1; cfg_delay = '0; stage_ack = '0;
      m_nrel = 0; m_done = 0; m_terr = 0; m_hold = 1; m_count = 0; m_wait = 0;

      // Zero-delay release with ACKs high: stages at E+2, E+5, E+8, done E+9.
      tbl[0]  = '{1'b0, 1'b1, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b001, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b001, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b001, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b011, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b011, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b011, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b111, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b111, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 8'd0, 3'b111, 3'b000, 1'b0, 1'b0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].rn, tbl[i].rq, tbl[i].d, tbl[i].ack);
         check3($sformatf("table[%0d]", i), tbl[i].exp_rst_n, tbl[i].exp_done, tbl[i].exp_terr);
      end

      // Nominal D=4: releases at E+6, E+13, E+20, done at E+21.
      cycle(1'b0, 1'b1, 8'd4, 3'b111);
      for (int k = 0; k < 22; k++) begin
         cycle(1'b1, 1'b0, 8'd4, 3'b111);
         check3($sformatf("nominal k=%0d", k), therm(n_exp(k, 4)), done_exp(k, 4), 1'b0);
      end

      // Stage 1 never ACKs: 16-edge dwell, forced advance, stage 2 still released.
      cycle(1'b0, 1'b1, 8'd1, 3'b001);
      for (int k = 0; k < 28; k++) begin
         cycle(1'b1, 1'b0, 8'd1, 3'b001);
         if (k == 22) check3("timeout_pre", 3'b011, 1'b0, 1'b0);
         if (k == 23) check3("timeout_set", 3'b011, 1'b0, 1'b1);
         if (k == 25) check3("stage2_wait", 3'b011, 1'b0, 1'b1);
         if (k == 26) check3("stage2_rel", 3'b111, 1'b0, 1'b1);
      end
      cycle(1'b1, 1'b1, 8'd1, 3'b001);
      check3("terr_sticky_req", 3'b000, 1'b0, 1'b1);
      for (int j = 0; j < 10; j++) cycle(1'b1, 1'b0, 8'd1, 3'b001);
      check3("terr_wait_ack", 3'b011, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 8'd1, 3'b001);
      check3("reset_mid_op", 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 8'd3, 3'b111);
         check3($sformatf("resume k=%0d", k), therm(n_exp(k, 3)), done_exp(k, 3), 1'b0);
      end

      // Mid-sequence request after stage 0, then full restart from stage 0.
      cycle(1'b0, 1'b1, 8'd2, 3'b111);
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'd2, 3'b111);
      check3("midseq_pre", 3'b001, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'd2, 3'b111);
      check3("midseq_req", 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 1'b0, 8'd2, 3'b111);
         check3($sformatf("restart k=%0d", k), therm(n_exp(k, 2)), done_exp(k, 2), 1'b0);
      end

      // Request on the same edge as the final ACK: the request wins.
      cycle(1'b0, 1'b1, 8'd0, 3'b111);
      for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 8'd0, 3'b111);
      check3("simul_pre", 3'b111, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'd0, 3'b111);
      check3("simul_req", 3'b000, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'd0, 3'b111);
      check3("simul_after", 3'b000, 1'b0, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic          rn;
         logic          rq;
         logic [DW-1:0] d;
         logic [N-1:0]  ack;
         rn  = ($urandom_range(0, 199) != 0);
         rq  = ($urandom_range(0, 59) == 0);
         d   = DW'($urandom_range(0, 4));
         ack = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 7)) : 3'b000;
         cycle(rn, rq, d, ack);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
